// File: rtl/gate_arb_pkg.sv
// rtl/gate_arb_pkg.sv - shared FSM state type and evaluation function for gate_arb
package gate_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic eval_fn(input logic in1, input logic in2, input logic in3);
        return ~(in1 ^ in2) ^ in3;
    endfunction

endpackage

// File: rtl/gate_eval.sv
// rtl/gate_eval.sv - combinational evaluator dout = ~(in1 ^ in2) ^ in3
module gate_eval
    import gate_arb_pkg::*;
(
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic dout
);

    assign dout = eval_fn(in1, in2, in3);

endmodule

// File: rtl/gate_arb.sv
// rtl/gate_arb.sv - arbitrates N_REQ requesters onto one shared evaluator (IDLE/EVAL/RESP)
// GATE_ARB_RR_EN selects round-robin arbitration; default is fixed lowest-index priority.
module gate_arb
    import gate_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               areset,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] op_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_dout
);

    state_t           state, state_next;
    logic [N_REQ-1:0] gnt_next;
    logic             rsp_valid_next;
    logic             found;
    logic [IDW-1:0]   win, win_q;
    logic [2:0]       ops_q;
    logic             eval_dout;

`ifdef GATE_ARB_RR_EN
    logic [IDW-1:0]     ptr;
    logic [2*N_REQ-1:0] rot;

    // Rotating a doubled copy puts requester ptr at bit 0, so the search order starts at ptr.
    always_comb begin
        rot   = {req, req} >> ptr;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr <= '0;
        end else if (state == ST_IDLE && found) begin
            ptr <= (win == IDW'(N_REQ - 1)) ? '0 : win + IDW'(1);
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[k]) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_next     = state;
        gnt_next       = '0;
        rsp_valid_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_next = ST_EVAL;
                    gnt_next   = N_REQ'(1) << win;
                end
            end
            ST_EVAL: begin
                state_next     = ST_RESP;
                rsp_valid_next = 1'b1;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_next;
            gnt       <= gnt_next;
            rsp_valid <= rsp_valid_next;
        end
    end

    // Operands are captured only at the grant edge; rsp_id/rsp_dout hold between strobes.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ops_q    <= '0;
            win_q    <= '0;
            rsp_id   <= '0;
            rsp_dout <= 1'b0;
        end else begin
            if (state == ST_IDLE && found) begin
                ops_q <= op_in[3*win +: 3];
                win_q <= win;
            end
            if (state == ST_EVAL) begin
                rsp_id   <= win_q;
                rsp_dout <= eval_dout;
            end
        end
    end

    gate_eval u_eval (
        .in1  (ops_q[2]),
        .in2  (ops_q[1]),
        .in3  (ops_q[0]),
        .dout (eval_dout)
    );

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_gate_arb.sv
// tb/tb_gate_arb.sv - self-checking bench for gate_arb with a timeline model of grants/responses
module tb_gate_arb;

    localparam int N   = 3;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] op_in = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic           rsp_dout;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int gq[$];

    gate_arb #(.N_REQ(N)) dut (
        .clk       (clk),
        .areset    (rst),
        .req       (req),
        .op_in     (op_in),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a grant at edge k owns the evaluator until edge k+3; the response appears after edge k+1.
    int cyc = 0, free_at = 0, rsp_at = -1, ptr = 0, pend_id = 0;
    logic pend_dout = 1'b0;
    logic [N-1:0]   e_gnt = '0;
    logic           e_rv = 1'b0, e_busy = 1'b0, e_dout = 1'b0;
    logic [IDW-1:0] e_id = '0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; free_at = 0; rsp_at = -1; ptr = 0;
            e_gnt = '0; e_rv = 1'b0; e_busy = 1'b0; e_id = '0; e_dout = 1'b0;
        end else begin
            int w;
            logic a, b, c;
            cyc++;
            e_gnt = '0;
            if (cyc >= free_at && req != '0) begin
                w = pick(req, ptr);
                e_gnt[w] = 1'b1;
                a = op_in[3*w+2]; b = op_in[3*w+1]; c = op_in[3*w];
                pend_dout = ~(a ^ b) ^ c;
                pend_id = w;
                rsp_at = cyc + 1;
                free_at = cyc + 3;
`ifdef GATE_ARB_RR_EN
                ptr = (w + 1) % N;
`endif
            end
            e_rv = (cyc == rsp_at);
            if (e_rv) begin
                e_id = IDW'(pend_id);
                e_dout = pend_dout;
            end
            e_busy = (cyc < free_at - 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_gnt", gnt, e_gnt);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_rsp_valid", rsp_valid, e_rv);
            chk("cyc_rsp_id", rsp_id, e_id);
            chk("cyc_rsp_dout", rsp_dout, e_dout);
            for (int i = 0; i < N; i++)
                if (gnt[i]) gq.push_back(i);
        end
    end

    task automatic txn(input int i, input logic [2:0] ops, input logic chg, input logic exp_d);
        int n;
        n = 0;
        req[i] = 1'b1;
        op_in[3*i +: 3] = ops;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[i] && n < 8);
        chk("txn_gnt", gnt[i], 1);
        req[i] = 1'b0;
        if (chg) op_in[3*i +: 3] = ~ops;
        @(negedge clk);
        chk("txn_rsp_valid", rsp_valid, 1);
        chk("txn_rsp_id", rsp_id, i);
        chk("txn_rsp_dout", rsp_dout, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tt;
        int exp_order[6];
        tt = 8'b01101001;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_dout", rsp_dout, 0);

        // Single request straight after reset: gnt at T+1, response at T+2.
        rst = 1'b0;
        req = 3'b001;
        op_in = '0;
        @(negedge clk);
        chk("first_gnt", gnt, 3'b001);
        req = '0;
        @(negedge clk);
        chk("first_rsp_valid", rsp_valid, 1);
        chk("first_rsp_id", rsp_id, 0);
        chk("first_rsp_dout", rsp_dout, 1);
        @(negedge clk);
        chk("hold_rsp_valid", rsp_valid, 0);
        chk("hold_rsp_dout", rsp_dout, 1);

        for (int t = 0; t < 8; t++)
            txn(1, 3'(t), 1'b0, tt[t]);

        // Operands change during EVAL; result must reflect the grant-edge value.
        txn(2, 3'b110, 1'b1, 1'b1);
        @(negedge clk);

        gq.delete();
        req = 3'b111;
        repeat (18) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        chk("stream_grant_count", gq.size(), 6);
`ifdef GATE_ARB_RR_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 6; k++)
            if (k < gq.size()) chk("stream_order", gq[k], exp_order[k]);

        // Reset mid-transaction: abort, outputs clear, pointer restarts at 0.
        req = 3'b001;
        op_in = 9'b000_000_001;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt[0] && n < 8);
            chk("abort_gnt", gnt[0], 1);
        end
        req = '0;
        #1 rst = 1'b1;
        #1;
        chk("abort_gnt_clr", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_rsp_dout", rsp_dout, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b101;
        op_in = 9'b011_000_000;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 3'b001);
        req = '0;
        @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, 1);
        chk("post_rst_rsp_dout", rsp_dout, 1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
